// File: rtl/fetch_buffer.sv
// Instruction fetch stage: owns the PC, keeps one memory read in flight and
// queues returned words with their next-PC for decode (show-ahead FIFO).
//   state     | meaning
//   S_IDLE    | no request outstanding; may issue one
//   S_WAIT    | request outstanding; response gets pushed
//   S_DISCARD | request outstanding but made stale by a redirect; response dropped
module fetch_buffer #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          DEPTH    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable_fetch,
    input  logic                     enable_updatePC,
    input  logic                     br_taken,
    input  logic [15:0]              taddr,
    output logic                     instrmem_rd,
    output logic [15:0]              pc,
    input  logic                     imem_valid,
    input  logic [15:0]              imem_data,
    input  logic                     instr_pop,
    output logic                     instr_valid,
    output logic [15:0]              instr_dout,
    output logic [15:0]              npc_out,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [15:0]   pc_q, pc_d;
    logic [15:0]   req_npc_q, req_npc_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   instr_mem_q [DEPTH];
    logic [15:0]   npc_mem_q   [DEPTH];

    logic redirect;
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;

    assign redirect   = br_taken & enable_updatePC;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL);

    // Gated by reset so no request escapes while the block is held in reset.
    assign instrmem_rd = reset & (state_q == S_IDLE) & enable_fetch & ~fifo_full & ~redirect;
    assign push        = (state_q == S_WAIT) & imem_valid & ~redirect;
    assign pop         = instr_pop & ~fifo_empty & ~redirect;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (instrmem_rd) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_valid)    state_d = S_IDLE;
                else if (redirect) state_d = S_DISCARD;
            end
            S_DISCARD: if (imem_valid) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        req_npc_d = req_npc_q;
        if (redirect) begin
            pc_d = taddr;
        end else if (instrmem_rd) begin
            pc_d      = pc_q + 16'd1;
            req_npc_d = pc_q + 16'd1;
        end
    end

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop)      count_d = count_q + (AW + 1)'(1);
            else if (!push && pop) count_d = count_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_npc_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_npc_q <= req_npc_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible through count_q.
    always_ff @(posedge clock) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_data;
            npc_mem_q[wr_ptr_q]   <= req_npc_q;
        end
    end

    assign pc          = pc_q;
    assign fifo_count  = count_q;
    assign instr_valid = ~fifo_empty;
    assign instr_dout  = fifo_empty ? 16'h0 : instr_mem_q[rd_ptr_q];
    assign npc_out     = fifo_empty ? 16'h0 : npc_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: a queue-level reference model of the
// fetch stage plus a behavioural instruction memory with variable latency.
module tb_fetch_buffer;
    localparam logic [15:0] RST_PC = 16'h3000;
    localparam int          DEPTH  = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_fetch = 1'b0, enable_updatePC = 1'b0, br_taken = 1'b0;
    logic [15:0] taddr = '0;
    logic        instrmem_rd;
    logic [15:0] pc;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_data = '0;
    logic        instr_pop = 1'b0;
    logic        instr_valid;
    logic [15:0] instr_dout, npc_out;
    logic [$clog2(DEPTH):0] fifo_count;

    fetch_buffer #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .enable_fetch(enable_fetch),
        .enable_updatePC(enable_updatePC), .br_taken(br_taken), .taddr(taddr),
        .instrmem_rd(instrmem_rd), .pc(pc), .imem_valid(imem_valid),
        .imem_data(imem_data), .instr_pop(instr_pop), .instr_valid(instr_valid),
        .instr_dout(instr_dout), .npc_out(npc_out), .fifo_count(fifo_count)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [15:0] ins; logic [15:0] npc; } ent_t;
    ent_t        exp_q[$];
    logic [15:0] m_pc = RST_PC;
    logic [15:0] m_req_npc = '0;
    bit          outst = 0, stale = 0, exp_rd = 0;
    int          wait_left = 0;
    int          checks = 0, errors = 0;

    int ef_pct = 0, pop_pct = 0, br_pct = 0, spur_pct = 0;
    int fix_lat = 0;
    bit use_fix_data = 0;
    logic [15:0] fix_data = '0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    function automatic void compute_exp();
        exp_rd = reset && enable_fetch && (exp_q.size() < DEPTH) && !outst
                 && !(br_taken && enable_updatePC);
    endfunction

    // Effect of the clock edge just passed, from the inputs held during that cycle.
    function automatic void apply_model();
        if (!reset) return;
        if (br_taken && enable_updatePC) begin
            m_pc = taddr;
            exp_q.delete();
            if (outst && imem_valid) begin outst = 0; stale = 0; end
            else if (outst) stale = 1;
        end else begin
            if (outst && imem_valid) begin
                if (!stale) exp_q.push_back('{imem_data, m_req_npc});
                outst = 0;
                stale = 0;
            end
            if (exp_rd) begin
                m_req_npc = m_pc + 16'd1;
                m_pc      = m_pc + 16'd1;
                outst     = 1;
                wait_left = (fix_lat > 0 ? fix_lat : int'($urandom_range(1, 3))) - 1;
            end
        end
    endfunction

    function automatic void draw();
        enable_fetch    = ($urandom_range(0, 99) < ef_pct);
        instr_pop       = ($urandom_range(0, 99) < pop_pct);
        br_taken        = ($urandom_range(0, 99) < br_pct);
        enable_updatePC = ($urandom_range(0, 3) != 0);
        taddr           = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        imem_data       = use_fix_data ? fix_data : 16'($urandom);
        if (outst) begin
            if (wait_left == 0) imem_valid = 1'b1;
            else begin imem_valid = 1'b0; wait_left--; end
        end else begin
            imem_valid = ($urandom_range(0, 99) < spur_pct);
        end
        compute_exp();
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        apply_model();
        draw();
        #1;
    endtask

    task automatic model_reset();
        m_pc  = RST_PC;
        exp_q.delete();
        outst = 0;
        stale = 0;
        compute_exp();
    endtask

    always @(negedge clock) begin
        chk("instrmem_rd", 32'(instrmem_rd), 32'(exp_rd));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
        chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("instr_dout", 32'(instr_dout), 32'(exp_q[0].ins));
            chk("npc_out", 32'(npc_out), 32'(exp_q[0].npc));
            if (reset && instr_pop && !(br_taken && enable_updatePC))
                void'(exp_q.pop_front());
        end else begin
            chk("instr_dout_empty", 32'(instr_dout), 32'h0);
            chk("npc_out_empty", 32'(npc_out), 32'h0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] saved_pc;
        int          saved_cnt;
        bit          hit;

        // Reset release, latency-1 memory returning 16'h1234
        ef_pct = 100; pop_pct = 0; br_pct = 0; spur_pct = 0;
        fix_lat = 1; use_fix_data = 1; fix_data = 16'h1234;
        repeat (2) @(posedge clock);
        step();
        reset = 1'b1;
        compute_exp();
        #1;
        chk("first_req_rd", 32'(instrmem_rd), 32'h1);
        chk("first_req_pc", 32'(pc), 32'h3000);
        step();
        step();
        chk("first_valid", 32'(instr_valid), 32'h1);
        chk("first_dout", 32'(instr_dout), 32'h1234);
        chk("first_npc", 32'(npc_out), 32'h3001);

        // Fill with pop held low
        repeat (20) step();
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_no_rd", 32'(instrmem_rd), 32'h0);
        chk("full_pc", 32'(pc), 32'h3004);
        pop_pct = 100;
        step();
        pop_pct = 0;
        step();
        chk("pop_reenables_rd", 32'(instrmem_rd), 32'h1);

        // Redirect while waiting on latency-3 memory
        fix_lat = 3; use_fix_data = 0;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = outst && !imem_valid;
        end
        chk("wait_reached", 32'(hit), 32'h1);
        br_taken = 1'b1; enable_updatePC = 1'b1; taddr = 16'h4000;
        compute_exp();
        step();
        chk("redir_count", 32'(fifo_count), 32'd0);
        chk("redir_valid", 32'(instr_valid), 32'h0);
        chk("redir_pc", 32'(pc), 32'h4000);
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = instrmem_rd;
        end
        chk("post_redir_rd", 32'(hit), 32'h1);
        chk("post_redir_pc", 32'(pc), 32'h4000);
        chk("stale_not_pushed", 32'(fifo_count), 32'd0);

        // br_taken without enable_updatePC
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = !outst;
        end
        enable_fetch = 1'b0; instr_pop = 1'b0;
        br_taken = 1'b1; enable_updatePC = 1'b0; taddr = 16'h5555;
        compute_exp();
        saved_pc = m_pc; saved_cnt = exp_q.size();
        step();
        chk("nobr_pc", 32'(pc), 32'(saved_pc));
        chk("nobr_count", 32'(fifo_count), 32'(saved_cnt));

        // PC wrap at 16'hFFFF
        fix_lat = 1;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = !outst;
        end
        enable_fetch = 1'b1; instr_pop = 1'b0;
        br_taken = 1'b1; enable_updatePC = 1'b1; taddr = 16'hFFFF;
        compute_exp();
        step();
        chk("wrap_req_pc", 32'(pc), 32'hFFFF);
        chk("wrap_req_rd", 32'(instrmem_rd), 32'h1);
        step();
        step();
        chk("wrap_npc", 32'(npc_out), 32'h0000);
        chk("wrap_next_pc", 32'(pc), 32'h0000);
        chk("wrap_next_rd", 32'(instrmem_rd), 32'h1);

        // Simultaneous push and pop at count 2
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = (exp_q.size() == 2) && outst && imem_valid;
        end
        chk("pushpop_reached", 32'(hit), 32'h1);
        instr_pop = 1'b1;
        step();
        chk("pushpop_count", 32'(fifo_count), 32'd2);

        // Async reset mid-WAIT, then a late response
        fix_lat = 3;
        hit = 0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            hit = outst && !imem_valid;
        end
        chk("wait2_reached", 32'(hit), 32'h1);
        #1;
        reset = 1'b0;
        model_reset();
        ef_pct = 0; spur_pct = 100;
        repeat (2) step();
        reset = 1'b1;
        compute_exp();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_resp_count", 32'(fifo_count), 32'd0);
            chk("late_resp_valid", 32'(instr_valid), 32'h0);
        end

        // Randomized traffic
        fix_lat = 0;
        for (int blk = 0; blk < 15; blk++) begin
            ef_pct   = $urandom_range(50, 100);
            pop_pct  = $urandom_range(20, 90);
            br_pct   = $urandom_range(0, 10);
            spur_pct = $urandom_range(0, 30);
            repeat (200) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
